// File: rtl/axi4_burst_master_if.sv
// Bundles the command, write-stream, read-stream, status and AXI4 master channels of axi4_burst_master.
// The master modport is the burst engine's view; the slave modport is the view of whatever drives and consumes it.
interface axi4_burst_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [7:0]              cmd_len;

  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_valid;
  logic                    wr_ready;

  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_last;
  logic                    rd_valid;
  logic                    rd_ready;

  logic                    sts_valid;
  logic [1:0]              sts_resp;

  logic [ID_WIDTH-1:0]     m_axi_awid;
  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [7:0]              m_axi_awlen;
  logic [2:0]              m_axi_awsize;
  logic [1:0]              m_axi_awburst;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;

  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wlast;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;

  logic [ID_WIDTH-1:0]     m_axi_bid;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;

  logic [ID_WIDTH-1:0]     m_axi_arid;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [7:0]              m_axi_arlen;
  logic [2:0]              m_axi_arsize;
  logic [1:0]              m_axi_arburst;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;

  logic [ID_WIDTH-1:0]     m_axi_rid;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rlast;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_data, wr_strb, wr_valid,
    output wr_ready,
    output rd_data, rd_last, rd_valid,
    input  rd_ready,
    output sts_valid, sts_resp,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_data, wr_strb, wr_valid,
    input  wr_ready,
    input  rd_data, rd_last, rd_valid,
    output rd_ready,
    input  sts_valid, sts_resp,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready
  );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator; address phase issues the cycle after command accept.
// Write/read data are zero-latency pass-throughs, so stream backpressure maps directly onto WREADY/RREADY.
module axi4_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic                aclk,
  input  logic                areset,
  axi4_burst_master_if.master bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_AW   = 3'd1;
  localparam logic [2:0] ST_W    = 3'd2;
  localparam logic [2:0] ST_B    = 3'd3;
  localparam logic [2:0] ST_AR   = 3'd4;
  localparam logic [2:0] ST_R    = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  localparam logic [2:0]          AXSIZE     = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [1:0]          BURST_INCR = 2'b01;
  localparam logic [ID_WIDTH-1:0] AXID       = ID_WIDTH'(AXI_ID);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [1:0]            accum_q;

  logic accept;
  logic w_hs;
  logic w_last_hs;
  logic r_hs;
  logic b_hs;

  assign accept    = bus.cmd_valid && bus.cmd_ready;
  assign w_hs      = bus.m_axi_wvalid && bus.m_axi_wready;
  assign w_last_hs = w_hs && (cnt_q == len_q);
  assign r_hs      = bus.m_axi_rvalid && bus.m_axi_rready;
  assign b_hs      = bus.m_axi_bvalid && bus.m_axi_bready;

  // Gating with areset keeps cmd_ready low while reset is held, not just after it.
  assign bus.cmd_ready = (state == ST_IDLE) && !areset;

  assign bus.m_axi_awid    = AXID;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = len_q;
  assign bus.m_axi_awsize  = AXSIZE;
  assign bus.m_axi_awburst = BURST_INCR;
  assign bus.m_axi_awvalid = (state == ST_AW);

  assign bus.m_axi_wdata  = bus.wr_data;
  assign bus.m_axi_wstrb  = bus.wr_strb;
  assign bus.m_axi_wvalid = (state == ST_W) && bus.wr_valid;
  assign bus.m_axi_wlast  = (state == ST_W) && (cnt_q == len_q);
  assign bus.wr_ready     = (state == ST_W) && bus.m_axi_wready;

  assign bus.m_axi_bready = (state == ST_B);

  assign bus.m_axi_arid    = AXID;
  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arlen   = len_q;
  assign bus.m_axi_arsize  = AXSIZE;
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_arvalid = (state == ST_AR);

  assign bus.m_axi_rready = (state == ST_R) && bus.rd_ready;
  assign bus.rd_valid     = (state == ST_R) && bus.m_axi_rvalid;
  assign bus.rd_data      = bus.m_axi_rdata;
  assign bus.rd_last      = (state == ST_R) && bus.m_axi_rlast;

  assign bus.sts_valid = (state == ST_DONE);
  assign bus.sts_resp  = accum_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = bus.cmd_write ? ST_AW : ST_AR;
      ST_AW:   if (bus.m_axi_awready) state_nxt = ST_W;
      ST_W:    if (w_last_hs) state_nxt = ST_B;
      ST_B:    if (b_hs) state_nxt = ST_DONE;
      ST_AR:   if (bus.m_axi_arready) state_nxt = ST_R;
      // rlast ends the burst regardless of how many beats actually arrived
      ST_R:    if (r_hs && bus.m_axi_rlast) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      accum_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= bus.cmd_addr;
        len_q   <= bus.cmd_len;
        cnt_q   <= '0;
        accum_q <= 2'b00;
      end
      if (w_hs) cnt_q <= cnt_q + 8'd1;
      if (b_hs) accum_q <= bus.m_axi_bresp;
      // Response codes are ordered by severity, so a numeric max keeps the worst one.
      if (r_hs && (bus.m_axi_rresp > accum_q)) accum_q <= bus.m_axi_rresp;
    end
  end

  a_aw_stable: assert property (@(posedge aclk) disable iff (areset)
    (bus.m_axi_awvalid && !bus.m_axi_awready) |=> (bus.m_axi_awvalid && $stable(bus.m_axi_awaddr)));

  a_ar_stable: assert property (@(posedge aclk) disable iff (areset)
    (bus.m_axi_arvalid && !bus.m_axi_arready) |=> (bus.m_axi_arvalid && $stable(bus.m_axi_araddr)));

endmodule
